// File: rtl/traffic_ctrl_nway_if.sv
// Lamp/demand bundle for traffic_ctrl_nway; master drives controls and demand,
// slave (the controller) drives the lamp outputs.
interface traffic_ctrl_nway_if #(
    parameter int NUM_DIR = 2
);
    localparam int IDX_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    logic               TEST;
    logic               CLR;
    logic [NUM_DIR-1:0] REQ;
    logic [NUM_DIR-1:0] RED;
    logic [NUM_DIR-1:0] YLW;
    logic [NUM_DIR-1:0] GRN;
    logic [IDX_W-1:0]   PHASE_DIR;

    modport master (
        output TEST, CLR, REQ,
        input  RED, YLW, GRN, PHASE_DIR
    );

    modport slave (
        input  TEST, CLR, REQ,
        output RED, YLW, GRN, PHASE_DIR
    );
endinterface

// File: rtl/traffic_ctrl_nway.sv
// Sensor-actuated N-way traffic controller: round-robin service, min/max green
// with gap-out, fixed yellow and all-red clearance, single-cycle TEST mode.
module traffic_ctrl_nway #(
    parameter int NUM_DIR     = 2,
    parameter int CNT_W       = 8,
    parameter int GRN_MIN     = 16,
    parameter int GRN_MAX     = 48,
    parameter int YLW_TIME    = 4,
    parameter int ALLRED_TIME = 2
) (
    input logic                blif_clk_net,
    input logic                blif_reset_net,
    traffic_ctrl_nway_if.slave bus
);
    localparam int IDX_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GRN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GRN_MAX - 1);
    localparam logic [CNT_W-1:0] YLW_LAST  = CNT_W'(YLW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_TIME - 1);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_cur;
    logic [CNT_W-1:0]   r_timer;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_cur_nxt;
    logic [CNT_W-1:0]   w_min_last;
    logic [CNT_W-1:0]   w_max_last;
    logic [CNT_W-1:0]   w_ylw_last;
    logic [CNT_W-1:0]   w_ar_last;
    logic [NUM_DIR-1:0] w_onehot;
    logic               w_other;
    logic               w_rr_found;
    logic [IDX_W-1:0]   w_rr_idx;

    // Comparisons use >= so that a TEST change mid-phase exits immediately
    // when the timer is already past the new limit.
    always_comb begin
        w_min_last = bus.TEST ? '0 : GMIN_LAST;
        w_max_last = bus.TEST ? '0 : GMAX_LAST;
        w_ylw_last = bus.TEST ? '0 : YLW_LAST;
        w_ar_last  = bus.TEST ? '0 : AR_LAST;
    end

    always_comb begin
        w_onehot = {{(NUM_DIR-1){1'b0}}, 1'b1} << r_cur;
        w_other  = |(bus.REQ & ~w_onehot);
    end

    // Scan cur+1 .. cur+NUM_DIR-1; with no demand, simply advance by one.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = IDX_W'((32'(r_cur) + 32'd1) % 32'(NUM_DIR));
        for (int unsigned k = 1; k < NUM_DIR; k++) begin
            if (!w_rr_found && bus.REQ[IDX_W'((32'(r_cur) + k) % 32'(NUM_DIR))]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'((32'(r_cur) + k) % 32'(NUM_DIR));
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        unique case (r_state)
            S_ALLRED: begin
                if (r_timer >= w_ar_last) begin
                    w_state_nxt = S_GREEN;
                    w_cur_nxt   = w_rr_idx;
                end
            end
            S_GREEN: begin
                if (w_other && ((r_timer >= w_min_last && !bus.REQ[r_cur]) ||
                                (r_timer >= w_max_last))) begin
                    w_state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (r_timer >= w_ylw_last) begin
                    w_state_nxt = S_ALLRED;
                end
            end
            default: w_state_nxt = S_ALLRED;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_state <= S_ALLRED;
            r_timer <= '0;
            r_cur   <= IDX_W'(NUM_DIR - 1);
        end else if (bus.CLR) begin
            r_state <= S_ALLRED;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (!(r_state == S_GREEN && r_timer >= w_max_last)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        bus.RED       = '1;
        bus.YLW       = '0;
        bus.GRN       = '0;
        bus.PHASE_DIR = r_cur;
        unique case (r_state)
            S_GREEN: begin
                bus.RED = ~w_onehot;
                bus.GRN = w_onehot;
            end
            S_YELLOW: begin
                bus.RED = ~w_onehot;
                bus.YLW = w_onehot;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench: a 2-way controller for idle/gap/max/TEST/CLR/reset phases and
// a 4-way controller for round-robin wrap-around.
module tb_traffic_ctrl_nway;
    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    traffic_ctrl_nway_if #(.NUM_DIR(2)) ifa ();
    traffic_ctrl_nway_if #(.NUM_DIR(4)) ifb ();

    traffic_ctrl_nway #(.NUM_DIR(2)) dut_a (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .bus            (ifa)
    );

    traffic_ctrl_nway #(.NUM_DIR(4)) dut_b (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .bus            (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input string tag, input logic [3:0] r,
                       input logic [3:0] y, input logic [3:0] g, input logic [1:0] pd);
        logic [13:0] obs;
        logic [13:0] exp_v;
        if (sel == 0)
            obs = {2'b00, ifa.RED, 2'b00, ifa.YLW, 2'b00, ifa.GRN, 1'b0, ifa.PHASE_DIR};
        else
            obs = {ifb.RED, ifb.YLW, ifb.GRN, ifb.PHASE_DIR};
        exp_v = {r, y, g, pd};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed R/Y/G/PD=%h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_n(input int sel, input string tag, input int n, input logic [3:0] r,
                            input logic [3:0] y, input logic [3:0] g, input logic [1:0] pd);
        for (int i = 0; i < n; i++) begin
            chk(sel, tag, r, y, g, pd);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifa.TEST = 1'b0; ifa.CLR = 1'b0; ifa.REQ = 2'b00;
        ifb.TEST = 1'b0; ifb.CLR = 1'b0; ifb.REQ = 4'b0000;

        // 1: idle after reset
        do_reset();
        chk(1, "rst_b", 4'b1111, 4'b0000, 4'b0000, 2'd3);
        expect_n(0, "t1_allred", 2,   4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t1_idle_g0", 200, 4'b0010, 4'b0000, 4'b0001, 2'd0);

        // 2: gap-out
        ifa.REQ = 2'b10;
        do_reset();
        expect_n(0, "t2_allred0", 2,  4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t2_g0",      16, 4'b0010, 4'b0000, 4'b0001, 2'd0);
        expect_n(0, "t2_y0",      4,  4'b0010, 4'b0001, 4'b0000, 2'd0);
        expect_n(0, "t2_allred1", 2,  4'b0011, 4'b0000, 4'b0000, 2'd0);
        expect_n(0, "t2_g1",      5,  4'b0001, 4'b0000, 4'b0010, 2'd1);

        // 3: max-out, full 108-cycle period
        ifa.REQ = 2'b11;
        do_reset();
        expect_n(0, "t3_allred0", 2,  4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t3_g0",      48, 4'b0010, 4'b0000, 4'b0001, 2'd0);
        expect_n(0, "t3_y0",      4,  4'b0010, 4'b0001, 4'b0000, 2'd0);
        expect_n(0, "t3_allred1", 2,  4'b0011, 4'b0000, 4'b0000, 2'd0);
        expect_n(0, "t3_g1",      48, 4'b0001, 4'b0000, 4'b0010, 2'd1);
        expect_n(0, "t3_y1",      4,  4'b0001, 4'b0010, 4'b0000, 2'd1);
        expect_n(0, "t3_allred2", 2,  4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t3_g0_again", 3, 4'b0010, 4'b0000, 4'b0001, 2'd0);

        // 4: TEST mode, one cycle per phase
        ifa.TEST = 1'b1;
        do_reset();
        expect_n(0, "t4_allred0", 1, 4'b0011, 4'b0000, 4'b0000, 2'd1);
        for (int k = 0; k < 2; k++) begin
            expect_n(0, "t4_g0", 1, 4'b0010, 4'b0000, 4'b0001, 2'd0);
            expect_n(0, "t4_y0", 1, 4'b0010, 4'b0001, 4'b0000, 2'd0);
            expect_n(0, "t4_r0", 1, 4'b0011, 4'b0000, 4'b0000, 2'd0);
            expect_n(0, "t4_g1", 1, 4'b0001, 4'b0000, 4'b0010, 2'd1);
            expect_n(0, "t4_y1", 1, 4'b0001, 4'b0010, 4'b0000, 2'd1);
            expect_n(0, "t4_r1", 1, 4'b0011, 4'b0000, 4'b0000, 2'd1);
        end
        ifa.TEST = 1'b0;

        // 5: 4-way round-robin wrap from dir 1 to dir 0
        ifb.REQ = 4'b0010;
        do_reset();
        expect_n(1, "t5_allred0", 2,  4'b1111, 4'b0000, 4'b0000, 2'd3);
        expect_n(1, "t5_g1",      20, 4'b1101, 4'b0000, 4'b0010, 2'd1);
        ifb.REQ = 4'b0001;
        expect_n(1, "t5_g1_t20",  1,  4'b1101, 4'b0000, 4'b0010, 2'd1);
        expect_n(1, "t5_y1",      4,  4'b1101, 4'b0010, 4'b0000, 2'd1);
        expect_n(1, "t5_allred1", 2,  4'b1111, 4'b0000, 4'b0000, 2'd1);
        expect_n(1, "t5_g0",      3,  4'b1110, 4'b0000, 4'b0001, 2'd0);

        // 6: CLR mid-green, then CLR+reset mid-yellow
        ifa.REQ = 2'b11;
        do_reset();
        expect_n(0, "t6_allred0", 2, 4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t6_g0",      5, 4'b0010, 4'b0000, 4'b0001, 2'd0);
        ifa.CLR = 1'b1;
        expect_n(0, "t6_g0_t5",   1, 4'b0010, 4'b0000, 4'b0001, 2'd0);
        ifa.CLR = 1'b0;
        expect_n(0, "t6_clr_red", 2, 4'b0011, 4'b0000, 4'b0000, 2'd0);
        expect_n(0, "t6_g1",     48, 4'b0001, 4'b0000, 4'b0010, 2'd1);
        expect_n(0, "t6_y1",      2, 4'b0001, 4'b0010, 4'b0000, 2'd1);
        ifa.CLR = 1'b1;
        rst = 1'b1;
        expect_n(0, "t6_y1_mid",  1, 4'b0001, 4'b0010, 4'b0000, 2'd1);
        ifa.CLR = 1'b0;
        rst = 1'b0;
        expect_n(0, "t6_rst_red", 2, 4'b0011, 4'b0000, 4'b0000, 2'd1);
        expect_n(0, "t6_g0_post", 2, 4'b0010, 4'b0000, 4'b0001, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_ctrl_nway.md
# traffic_ctrl_nway

Parametrised, sensor-actuated traffic-light controller for an intersection of `NUM_DIR` approaches. It generalises the fixed two-road controller with these additions:

- configurable phase durations;
- per-direction demand inputs;
- min/max green with gap-out;
- round-robin service across any number of directions;
- a TEST mode that collapses every phase to one cycle.

It is a standalone sequential benchmark block driven by the shared benchmark clock and reset nets.

## Interface

Parameters:

- `NUM_DIR`, 2 — number of approaches; must be ≥2.
- `CNT_W`, 8 — phase timer width; every duration must be ≤ 2^CNT_W.
- `GRN_MIN`, 16 — minimum green, in cycles (≥1).
- `GRN_MAX`, 48 — maximum green when another direction is waiting (≥ `GRN_MIN`).
- `YLW_TIME`, 4 — yellow duration, in cycles (≥1).
- `ALLRED_TIME`, 2 — all-red clearance, in cycles (≥1).
- `IDX_W`, derived as clog2(`NUM_DIR`) — width of the direction index; not user-set.

Ports:

- `blif_clk_net` input 1 — single clock, rising edge.
- `blif_reset_net` input 1 — synchronous, active-high reset.
- `TEST` input 1 — when 1, every phase lasts exactly 1 cycle.
- `CLR` input 1 — synchronous clear to all-red.
- `REQ` input `NUM_DIR` — demand sensor per direction, synchronous to `blif_clk_net`.
- `RED` output `NUM_DIR` — red lamp per direction.
- `YLW` output `NUM_DIR` — yellow lamp per direction.
- `GRN` output `NUM_DIR` — green lamp per direction.
- `PHASE_DIR` output `IDX_W` — index of the direction currently or last served.

## Operation

Registered state:

- `state` ∈ {ALLRED, GREEN, YELLOW};
- `cur` (`IDX_W` bits);
- `timer` (`CNT_W` bits).

Outputs are a pure decode of these registers. There is no combinational path from any input to any output.

Output decode:

- GREEN: `GRN[cur]`=1; `RED` = all ones except bit `cur`.
- YELLOW: `YLW[cur]`=1; `RED` = all ones except bit `cur`.
- ALLRED: `RED` = all ones; `YLW` = 0; `GRN` = 0.
- In every state exactly one lamp per direction is lit.

Reset (highest priority):

- `state`=ALLRED, `timer`=0, `cur`=`NUM_DIR`-1.
- Outputs: `RED` all ones, `YLW`=0, `GRN`=0, `PHASE_DIR`=`NUM_DIR`-1.

`CLR` (when not in reset):

- `state`=ALLRED, `timer`=0; `cur` is held.

Timer rules:

- `timer` clears on every state change.
- Otherwise `timer` increments, saturating at `GRN_MAX`-1 in GREEN.
- A state lasts D cycles when its exit is taken at `timer`==D-1.

Effective durations:

- `TEST`=0: the parameter values.
- `TEST`=1: `GRN_MIN`=`GRN_MAX`=`YLW_TIME`=`ALLRED_TIME`=1.

Transitions, evaluated each cycle on current `REQ`:

- ALLRED → GREEN when `timer` == `ALLRED_TIME`-1. The new `cur` is chosen then by round-robin (see below).
- GREEN → YELLOW when `other` = |(`REQ` with bit `cur` masked) is 1, and either:
  - `timer` ≥ `GRN_MIN`-1 and `REQ[cur]`=0 (gap-out), or
  - `timer` ≥ `GRN_MAX`-1 (max-out).
- GREEN with `other`=0 rests in green indefinitely (timer saturated).
- YELLOW → ALLRED when `timer` == `YLW_TIME`-1.

Round-robin selection:

- Scan (`cur`+1), (`cur`+2), … mod `NUM_DIR`.
- The first index with `REQ`=1 becomes the new `cur`.
- If no bit of `REQ` is set, `cur` = (`cur`+1) mod `NUM_DIR`.
- Wrap-around from `NUM_DIR`-1 to 0 is mandatory.

Priority on simultaneous events: `blif_reset_net` > `CLR` > normal transition.

Mid-operation events:

- `CLR` during GREEN or YELLOW cuts straight to all-red. No yellow is inserted; this is a deliberate emergency clear.
- `TEST` toggling mid-phase takes effect on the next comparison. If `timer` already exceeds the new limit, the exit is taken that cycle.

## Timing

- All state updates occur on the rising edge of `blif_clk_net`.
- Outputs change on the edge after the causing input is sampled: one cycle from input to output.
- First green after reset release:
  - reset sampled at edge 0;
  - ALLRED during cycles 1..`ALLRED_TIME`;
  - `GRN[0]` from cycle `ALLRED_TIME`+1.
- Minimum full cycle for one direction: `GRN_MIN` + `YLW_TIME` + `ALLRED_TIME`.
- In `TEST` mode this is 3 cycles.
- `REQ` is not latched. A request must be held until served; a pulse shorter than the evaluation cycle is lost.

## Test plan

1. **Idle after reset.** Defaults, reset 1 cycle, `REQ`=0.
   - `RED`=2'b11 for 2 cycles.
   - Then `GRN`=2'b01, `PHASE_DIR`=0, held for 200 cycles.
2. **Gap-out.** `REQ`=2'b10 held from reset release.
   - `GRN[0]` for exactly 16 cycles.
   - Then `YLW`=2'b01 for 4 cycles, then `RED`=2'b11 for 2 cycles.
   - Then `GRN`=2'b10 and `PHASE_DIR`=1.
3. **Max-out.** `REQ`=2'b11 held.
   - `GRN[0]` for 48 cycles, then yellow 4 cycles, then all-red 2 cycles.
   - Then `GRN[1]` for 48 cycles; the cycle repeats with a period of 108.
4. **TEST mode.** `TEST`=1, `REQ`=2'b11.
   - Repeating 6-cycle sequence: G0, Y0, R, G1, Y1, R.
   - Every phase lasts exactly 1 cycle.
5. **Round-robin wrap.** `NUM_DIR`=4, dir 1 green, `REQ`=4'b0001 asserted at `timer`=20 with `REQ[1]`=0.
   - Yellow next cycle (gap-out), 4 cycles.
   - All-red 2 cycles, skipping dirs 2 and 3.
   - `GRN`=4'b0001, `PHASE_DIR`=0.
6. **CLR and reset priority.**
   - `CLR` pulse at green `timer`=5: all-red on the next cycle for 2 cycles, then round-robin to the other direction.
   - `CLR` and reset together mid-yellow: reset values on the next cycle, `PHASE_DIR`=`NUM_DIR`-1.
